// File: rtl/ex_cpuid_ent.sv
`default_nettype none
// ============================================================================
// Module   : ex_cpuid_ent
// Brief    : EX-stage CPUID leaf unit with LFSR RNG, entropy credits and a
//            sticky noise-health monitor. CPUID_RNG_WHITEN_EN enables whitening.
// Revision : 1.0
// ============================================================================
module ex_cpuid_ent #(
    parameter int          IDX_BITS   = 5,
    parameter int          CORE_ID    = 0,
    parameter logic [55:0] FEAT_BITS  = 56'h0,
    parameter int          RNG_LANES  = 2,
    parameter int          POOL_MAX   = 64,
    parameter int          POOL_MIN   = 16,
    parameter int          HEALTH_WIN = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [11:0]         timers,
    input  logic                reqValid,
    input  logic [IDX_BITS-1:0] reqIndex,
    input  logic                reqClr,
    output logic                resValid,
    output logic [63:0]         resLo,
    output logic [63:0]         resHi
);

    localparam logic [IDX_BITS-1:0] C_LEAF_ID   = IDX_BITS'(0);
    localparam logic [IDX_BITS-1:0] C_LEAF_CORE = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0] C_LEAF_CFG  = IDX_BITS'(2);
    localparam logic [IDX_BITS-1:0] C_LEAF_STAT = IDX_BITS'(3);
    localparam logic [IDX_BITS-1:0] C_LEAF_RNG  = '1;
    localparam logic [63:0]         C_VENDOR    = 64'h2020_3246_3258_4A42;
    localparam int                  C_RUN_W     = $clog2(HEALTH_WIN + 1);

    logic                r_s1, r_s2, r_noise, r_prevNoise;
    logic [C_RUN_W-1:0]  r_run;
    logic                r_fail;
    logic [7:0]          r_credits;
    logic [31:0]         r_rdCnt;
    logic [31:0]         r_lane [RNG_LANES];
    logic [RNG_LANES-1:0] r_lastFb;

    logic [RNG_LANES-1:0] w_fb;
    logic [31:0]         w_r0, w_r1;
    logic [63:0]         w_raw, w_rng;
    logic                w_rngRd, w_statRd, w_fresh, w_consume, w_gain, w_same, w_trip;
    logic [8:0]          w_sum;
    logic [7:0]          w_creditsNext;
    logic [63:0]         w_lo, w_hi;
    logic                w_unused;

    assign w_unused  = ^timers[7:1];
    assign w_rngRd   = reqValid && (reqIndex == C_LEAF_RNG);
    assign w_statRd  = reqValid && (reqIndex == C_LEAF_STAT);
    assign w_fresh   = !r_fail && (r_credits >= 8'(POOL_MIN));
    assign w_consume = w_rngRd && w_fresh;
    assign w_gain    = r_noise && !r_fail;
    assign w_same    = (r_noise == r_prevNoise);
    // Fail trips only on the edge the run reaches the window, so a clear sticks
    // even while the source remains stuck.
    assign w_trip    = w_same && (r_run == C_RUN_W'(HEALTH_WIN - 1));

    always_comb begin
        w_sum = {1'b0, r_credits} - (w_consume ? 9'(POOL_MIN) : 9'd0)
                + (w_gain ? 9'd1 : 9'd0);
        if (r_fail)
            w_creditsNext = 8'd0;
        else if (w_sum > 9'(POOL_MAX))
            w_creditsNext = 8'(POOL_MAX);
        else
            w_creditsNext = w_sum[7:0];
    end

    always_comb begin
        w_fb = '0;
        w_r0 = '0;
        w_r1 = '0;
        w_raw = '0;
        for (int k = 0; k < RNG_LANES; k++) begin
            w_fb[k] = r_lane[k][1] ^ r_lane[k][3] ^ r_lane[k][5] ^ r_lane[k][7]
                      ^ r_noise ^ r_lastFb[(k + RNG_LANES - 1) % RNG_LANES] ^ 1'b1;
            if (k % 2 == 0)
                w_r0 = w_r0 ^ r_lane[k];
            else
                w_r1 = w_r1 ^ r_lane[k];
        end
        // Pair 0 sits at the top byte: even-lane nibbles descend, odd-lane ascend.
        for (int i = 0; i < 8; i++)
            w_raw[63-8*i -: 8] = {w_r0[31-4*i -: 4], w_r1[4*i +: 4]};
    end

`ifdef CPUID_RNG_WHITEN_EN
    logic [63:0] r_prev;
    assign w_rng = w_raw ^ {r_prev[50:0], r_prev[63:51]};
    always_ff @(posedge clock) begin
        if (reset)
            r_prev <= '0;
        else if (w_rngRd)
            r_prev <= w_rng;
    end
`else
    assign w_rng = w_raw;
`endif

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        if (reqIndex == C_LEAF_RNG) begin
            w_lo = w_rng;
            w_hi = {62'd0, r_fail, w_fresh};
        end else begin
            case (reqIndex)
                C_LEAF_ID:   w_lo = C_VENDOR;
                C_LEAF_CORE: w_lo = {FEAT_BITS, 4'(CORE_ID), timers[11:8]};
                C_LEAF_CFG:  w_lo = {32'h0, 8'(RNG_LANES), 8'(POOL_MIN),
                                     8'(POOL_MAX), 8'(IDX_BITS)};
                C_LEAF_STAT: w_lo = {r_rdCnt, 15'h0, r_fail, 8'h0, r_credits};
                default:     w_lo = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_noise     <= 1'b0;
            r_prevNoise <= 1'b0;
            r_run       <= '0;
            r_fail      <= 1'b0;
            r_credits   <= 8'd0;
            r_rdCnt     <= 32'd0;
            r_lastFb    <= '0;
            for (int k = 0; k < RNG_LANES; k++)
                r_lane[k] <= 32'h1357_9BDF ^ (32'(k) * 32'h1111_1111);
            resValid    <= 1'b0;
            resLo       <= '0;
            resHi       <= '0;
        end else begin
            r_s1        <= timers[0];
            r_s2        <= r_s1;
            r_noise     <= r_s1 ^ r_s2;
            r_prevNoise <= r_noise;
            if (!w_same)
                r_run <= C_RUN_W'(1);
            else if (r_run != C_RUN_W'(HEALTH_WIN))
                r_run <= r_run + C_RUN_W'(1);
            if (w_trip)
                r_fail <= 1'b1;
            else if (w_statRd && reqClr)
                r_fail <= 1'b0;
            r_credits <= w_creditsNext;
            if (w_statRd && reqClr)
                r_rdCnt <= 32'd0;
            else if (w_rngRd)
                r_rdCnt <= r_rdCnt + 32'd1;
            r_lastFb <= w_fb;
            for (int k = 0; k < RNG_LANES; k++)
                r_lane[k] <= {w_fb[k], r_lane[k][31:1]};
            resValid <= reqValid;
            if (reqValid) begin
                resLo <= w_lo;
                resHi <= w_hi;
            end
        end
    end

endmodule
`default_nettype wire
